// File: rtl/cpu_wb_pkg.sv
// Shared types and sizing helpers for the writeback arbiter and its round-robin sub-block.
// Supplies a fallback OP_MUL encoding when cpu.vh has not been included ahead of this file.
`ifndef OP_MUL
`define OP_MUL 6'h18
`endif

package cpu_wb_pkg;

  typedef enum logic [1:0] {WB_NONE, WB_PIPE, WB_MEM} wb_slot_t;

  localparam int unsigned REG_W        = 5;
  localparam int unsigned OP_W         = 6;
  localparam int unsigned MAX_MEM_CH   = 8;
  localparam int unsigned STARVE_W     = 4;

  // Index width for an N-entry channel set, never narrower than one bit.
  function automatic int unsigned mem_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned MEM_IDX_W = mem_idx_w(2);

endpackage

// File: rtl/cpu_rr_arbiter.sv
// Round-robin arbiter: first requester at or after pointer, wrapping N-1 -> 0.
// Produces a one-hot grant plus its binary index; idle when enable is low.
module cpu_rr_arbiter
  import cpu_wb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = mem_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [2*N-1:0] rotated;
  logic [IW:0]    sum;

  // Rotate so bit k of the low half is channel (pointer + k) mod N.
  assign rotated = {req, req} >> pointer;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = '0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        if (!grant_valid && rotated[k]) begin
          grant_valid = 1'b1;
          sum         = {1'b0, pointer} + (IW+1)'(k);
          if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
          grant_idx   = IW'(sum);
        end
      end
      if (grant_valid) grant = N'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/cpu_writeback_arb.sv
// Writeback stage: merges the ALU/MUL result with one round-robin memory return per cycle,
// stalling p4 when memory has waited too long. Optional counters under WB_PERF_COUNT_EN.
module cpu_writeback_arb
  import cpu_wb_pkg::*;
#(
  parameter int unsigned NUM_MEM_CH   = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [OP_W-1:0]              p4_op,
  input  logic [REG_W-1:0]             p4_dest,
  input  logic                         p4_dest_zero,
  input  logic [DATA_W-1:0]            p4_alu_result,
  input  logic [DATA_W-1:0]            p4_mult_result,
  output logic                         p4_stall,
  input  logic [NUM_MEM_CH-1:0]        mem_valid,
  output logic [NUM_MEM_CH-1:0]        mem_ready,
  input  logic [REG_W*NUM_MEM_CH-1:0]  mem_dest,
  input  logic [DATA_W*NUM_MEM_CH-1:0] mem_result,
  output logic                         p5u_write,
  output logic [REG_W-1:0]             p5u_dest_reg,
  output logic [DATA_W-1:0]            p5u_result,
  output logic                         p5_write,
  output logic [REG_W-1:0]             p5_dest_reg,
  output logic [DATA_W-1:0]            p5_result,
  output logic [31:0]                  perf_starve,
  output logic [31:0]                  perf_mem_wr
);

  localparam int unsigned IW = mem_idx_w(NUM_MEM_CH);

  wb_slot_t             slot;
  logic                 pipe_slot;
  logic                 grant_valid;
  logic [IW-1:0]        grant_idx;
  logic [IW-1:0]        rr_ptr, rr_next;
  logic [STARVE_W-1:0]  starve_cnt, starve_next;
  logic                 starve_inc;
  logic                 stall_next;
  logic [REG_W-1:0]     sel_dest;
  logic [DATA_W-1:0]    sel_result;

  assign pipe_slot = !p4_dest_zero && !p4_stall;

  cpu_rr_arbiter #(.N(NUM_MEM_CH), .IW(IW)) u_arb (
    .req         (mem_valid),
    .enable      (!pipe_slot),
    .pointer     (rr_ptr),
    .grant       (mem_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Slot selection and write-port mux; x0 writes are suppressed but still acknowledged.
  always_comb begin
    slot       = WB_NONE;
    sel_dest   = '0;
    sel_result = '0;
    if (pipe_slot) begin
      slot       = WB_PIPE;
      sel_dest   = p4_dest;
      sel_result = (p4_op == `OP_MUL) ? p4_mult_result : p4_alu_result;
    end else if (grant_valid) begin
      slot = WB_MEM;
      for (int i = 0; i < NUM_MEM_CH; i++) begin
        if (grant_idx == IW'(i)) begin
          sel_dest   = mem_dest[i*REG_W +: REG_W];
          sel_result = mem_result[i*DATA_W +: DATA_W];
        end
      end
    end
    p5u_write    = (slot != WB_NONE) && (sel_dest != '0);
    p5u_dest_reg = p5u_write ? sel_dest : '0;
    p5u_result   = p5u_write ? sel_result : '0;
  end

  // Next-state for the round-robin pointer, starvation counter and stall.
  always_comb begin
    rr_next     = rr_ptr;
    starve_next = '0;
    starve_inc  = (|mem_valid) && !grant_valid;
    if (grant_valid) begin
      rr_next = (grant_idx == IW'(NUM_MEM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (starve_inc) begin
      starve_next = (starve_cnt >= STARVE_W'(STARVE_LIMIT)) ? STARVE_W'(STARVE_LIMIT)
                                                            : starve_cnt + 1'b1;
    end
    stall_next = starve_inc && (starve_cnt >= STARVE_W'(STARVE_LIMIT - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= '0;
      starve_cnt  <= '0;
      p4_stall    <= 1'b0;
      p5_write    <= 1'b0;
      p5_dest_reg <= '0;
      p5_result   <= '0;
    end else begin
      rr_ptr      <= rr_next;
      starve_cnt  <= starve_next;
      p4_stall    <= stall_next;
      p5_write    <= p5u_write;
      p5_dest_reg <= p5u_dest_reg;
      p5_result   <= p5u_result;
    end
  end

`ifdef WB_PERF_COUNT_EN
  logic [31:0] starve_q, mem_wr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
      mem_wr_q <= '0;
    end else begin
      if (p4_stall) starve_q <= starve_q + 32'd1;
      if (|(mem_valid & mem_ready)) mem_wr_q <= mem_wr_q + 32'd1;
    end
  end

  assign perf_starve = starve_q;
  assign perf_mem_wr = mem_wr_q;
`else
  assign perf_starve = '0;
  assign perf_mem_wr = '0;
`endif

endmodule

// File: tb/tb_cpu_writeback_arb.sv
// Directed bench: a driver pushes hand-computed expectations per cycle, a monitor pops and compares.
`ifndef OP_MUL
`define OP_MUL 6'h18
`endif

module tb_cpu_writeback_arb;

  localparam logic [5:0] OP_ADD = 6'h00;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  p4_op;
  logic [4:0]  p4_dest;
  logic        p4_dest_zero;
  logic [31:0] p4_alu_result, p4_mult_result;
  logic        p4_stall;
  logic [1:0]  mem_valid, mem_ready;
  logic [9:0]  mem_dest;
  logic [63:0] mem_result;
  logic        p5u_write, p5_write;
  logic [4:0]  p5u_dest_reg, p5_dest_reg;
  logic [31:0] p5u_result, p5_result;
  logic [31:0] perf_starve, perf_mem_wr;

  always #5 clock = ~clock;

  cpu_writeback_arb dut (
    .clock(clock), .reset(reset),
    .p4_op(p4_op), .p4_dest(p4_dest), .p4_dest_zero(p4_dest_zero),
    .p4_alu_result(p4_alu_result), .p4_mult_result(p4_mult_result),
    .p4_stall(p4_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_dest(mem_dest), .mem_result(mem_result),
    .p5u_write(p5u_write), .p5u_dest_reg(p5u_dest_reg), .p5u_result(p5u_result),
    .p5_write(p5_write), .p5_dest_reg(p5_dest_reg), .p5_result(p5_result),
    .perf_starve(perf_starve), .perf_mem_wr(perf_mem_wr)
  );

  typedef struct {
    int          id;
    logic        w;
    logic [4:0]  d;
    logic [31:0] r;
    logic [1:0]  rdy;
    logic        s;
    logic        p5w;
    logic [4:0]  p5d;
    logic [31:0] p5r;
    logic [31:0] ps;
    logic [31:0] pm;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          vec = 0;
  logic        prev_w = 1'b0;
  logic [4:0]  prev_d = '0;
  logic [31:0] prev_r = '0;
  logic [31:0] cnt_s = '0;
  logic [31:0] cnt_m = '0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", id, nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show during that cycle.
  task automatic step(input logic rst, input logic dz, input logic [5:0] op, input logic [4:0] dest,
                      input logic [31:0] alu, input logic [31:0] mul, input logic [1:0] mv,
                      input logic [4:0] d0, input logic [31:0] r0, input logic [4:0] d1,
                      input logic [31:0] r1, input logic ew, input logic [4:0] ed,
                      input logic [31:0] er, input logic [1:0] erdy, input logic es);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; p4_dest_zero = dz; p4_op = op; p4_dest = dest;
    p4_alu_result = alu; p4_mult_result = mul; mem_valid = mv;
    mem_dest = {d1, d0}; mem_result = {r1, r0};
    vec++;
    e.id = vec; e.w = ew; e.d = ed; e.r = er; e.rdy = erdy; e.s = es;
    e.p5w = prev_w; e.p5d = prev_d; e.p5r = prev_r;
`ifdef WB_PERF_COUNT_EN
    e.ps = cnt_s; e.pm = cnt_m;
`else
    e.ps = '0; e.pm = '0;
`endif
    q.push_back(e);
    if (rst) begin
      prev_w = 1'b0; prev_d = '0; prev_r = '0; cnt_s = '0; cnt_m = '0;
    end else begin
      prev_w = ew; prev_d = ed; prev_r = er;
      if (es) cnt_s++;
      if (erdy != 2'b00) cnt_m++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("p5u_write", e.id, 32'(p5u_write), 32'(e.w));
        chk("p5u_dest", e.id, 32'(p5u_dest_reg), 32'(e.d));
        chk("p5u_result", e.id, p5u_result, e.r);
        chk("mem_ready", e.id, 32'(mem_ready), 32'(e.rdy));
        chk("p4_stall", e.id, 32'(p4_stall), 32'(e.s));
        chk("p5_write", e.id, 32'(p5_write), 32'(e.p5w));
        chk("p5_dest", e.id, 32'(p5_dest_reg), 32'(e.p5d));
        chk("p5_result", e.id, p5_result, e.p5r);
        chk("perf_starve", e.id, perf_starve, e.ps);
        chk("perf_mem_wr", e.id, perf_mem_wr, e.pm);
      end
    end
  end

  initial begin : driver
    reset = 1'b1; p4_dest_zero = 1'b1; p4_op = OP_ADD; p4_dest = '0;
    p4_alu_result = '0; p4_mult_result = '0; mem_valid = '0; mem_dest = '0; mem_result = '0;
    repeat (2) @(posedge clock);
    // pipe only, then MUL select, then idle
    step(0, 0, OP_ADD,  5, 32'h1234, 32'hAAAA,     2'b00, 0, 0, 0, 0, 1, 5, 32'h1234, 2'b00, 0);
    step(0, 0, `OP_MUL, 7, 32'h1111, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 2'b00, 0);
    step(0, 1, OP_ADD,  0, 0, 0,                   2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    // round-robin with both channels valid
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) step(0, 1, OP_ADD, 0, 0, 0, 2'b11, 3, 32'h33, 4, 32'h44, 1, 3, 32'h33, 2'b01, 0);
      else            step(0, 1, OP_ADD, 0, 0, 0, 2'b11, 3, 32'h33, 4, 32'h44, 1, 4, 32'h44, 2'b10, 0);
    end
    // memory write to x0 is acknowledged but dropped; pipe write to x0 dropped
    step(0, 1, OP_ADD, 0, 0, 0,        2'b01, 0, 32'hFFFF, 0, 0, 0, 0, 0, 2'b01, 0);
    step(0, 0, OP_ADD, 0, 32'h55, 0,   2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    // starvation on ch1: four busy cycles, stall and grant on the fifth, stall gone on the sixth
    for (int i = 0; i < 4; i++)
      step(0, 0, OP_ADD, 9, 32'h900, 0, 2'b10, 0, 0, 6, 32'h66, 1, 9, 32'h900, 2'b00, 0);
    step(0, 0, OP_ADD, 9, 32'h900, 0, 2'b10, 0, 0, 6, 32'h66, 1, 6, 32'h66, 2'b10, 1);
    // starvation again, then mem_valid falls while stalled
    for (int i = 0; i < 4; i++)
      step(0, 0, OP_ADD, 9, 32'h900, 0, 2'b10, 0, 0, 6, 32'h66, 1, 9, 32'h900, 2'b00, 0);
    step(0, 0, OP_ADD, 9, 32'h900, 0, 2'b00, 0, 0, 6, 32'h66, 0, 0, 0, 2'b00, 1);
    step(0, 0, OP_ADD, 9, 32'h900, 0, 2'b00, 0, 0, 0, 0, 1, 9, 32'h900, 2'b00, 0);
    // starvation on ch0, reset while stalled; rr_ptr must restart at ch0
    for (int i = 0; i < 4; i++)
      step(0, 0, OP_ADD, 9, 32'h900, 0, 2'b01, 8, 32'h88, 0, 0, 1, 9, 32'h900, 2'b00, 0);
    step(1, 0, OP_ADD, 9, 32'h900, 0, 2'b01, 8, 32'h88, 0, 0, 1, 8, 32'h88, 2'b01, 1);
    step(0, 1, OP_ADD, 0, 0, 0, 2'b11, 3, 32'h33, 4, 32'h44, 1, 3, 32'h33, 2'b01, 0);
    step(0, 1, OP_ADD, 0, 0, 0, 2'b11, 3, 32'h33, 4, 32'h44, 1, 4, 32'h44, 2'b10, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d queued expectations left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
